// File: rtl/mcp3008_emu.sv
// mcp3008_emu: SPI responder emulating an MCP3008 8-channel ADC on the device end of the link.
// Ports: clk system clock (>= 8x sclk); aclr async reset; sclr sync clear (same effect);
//   sclk/csn/mosi SPI mode 0,0 inputs; miso/miso_oe device data and drive enable;
//   ch_val flattened channel values, channel i at [i*ADC_WIDTH +: ADC_WIDTH];
//   done/done_ch/done_sgl completed-frame pulse and its command; abort early-deselect pulse;
//   frame_cnt completed frames (wraps).
// Optional MCP3008_EMU_DIFF_EN: SGL=0 returns clamped pseudo-differential IN+ - IN-;
//   without it SGL=0 returns an all-zero word.
module mcp3008_emu #(
    parameter int ADC_WIDTH   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   sclr,
    input  logic                   sclk,
    input  logic                   csn,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [8*ADC_WIDTH-1:0] ch_val,
    output logic                   done,
    output logic [2:0]             done_ch,
    output logic                   done_sgl,
    output logic                   abort,
    output logic [15:0]            frame_cnt
);
    localparam int CW = $clog2(ADC_WIDTH);

    typedef enum logic [2:0] {IDLE, START, CMD, SAMPLE, NULLB, DATA, TAIL} state_t;

    // sclk/csn chains carry one extra flop holding the previous synced sample for edge detection
    logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   rise_q, rise_d, fall_q, fall_d, mosi_e_q, mosi_e_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [ADC_WIDTH-1:0]   shift_q, shift_d, sel_val, word;
    logic                   miso_q, miso_d, oe_q, oe_d, done_q, done_d, abort_q, abort_d;
    logic [2:0]             done_ch_q, done_ch_d;
    logic                   done_sgl_q, done_sgl_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   csn_s, csn_rise;
`ifdef MCP3008_EMU_DIFF_EN
    logic [ADC_WIDTH-1:0]   pair_val;
    logic [ADC_WIDTH:0]     diff;
`endif

    always_comb begin
        sel_val = ch_val[cmd_q[2:0]*ADC_WIDTH +: ADC_WIDTH];
`ifdef MCP3008_EMU_DIFF_EN
        pair_val = ch_val[(cmd_q[2:0] ^ 3'd1)*ADC_WIDTH +: ADC_WIDTH];
        diff     = {1'b0, sel_val} - {1'b0, pair_val};
        word     = cmd_q[3] ? sel_val : diff[ADC_WIDTH] ? '0 : diff[ADC_WIDTH-1:0];
`else
        word     = cmd_q[3] ? sel_val : '0;
`endif
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], sclk};
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-1:0], csn};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        csn_s       = csn_sync_q[SYNC_STAGES-1];
        csn_rise    = csn_s & ~csn_sync_q[SYNC_STAGES];
        // edges are registered so every SPI event acts one clock after detection
        rise_d      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES] & ~csn_s;
        fall_d      = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES] & ~csn_s;
        mosi_e_d    = mosi_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        done_ch_d   = done_ch_q;
        done_sgl_d  = done_sgl_q;
        frame_cnt_d = frame_cnt_q;
        if (csn_s) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            abort_d = csn_rise & (state_q inside {CMD, SAMPLE, NULLB, DATA});
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = START;
                    oe_d    = 1'b1;
                    miso_d  = 1'b0;
                end
                START: if (rise_q && mosi_e_q) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (rise_q) begin
                    cmd_d   = {cmd_q[2:0], mosi_e_q};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(3)) ? SAMPLE : CMD;
                end
                SAMPLE: if (rise_q) begin
                    shift_d = word;
                    state_d = NULLB;
                end
                NULLB: if (fall_q) begin
                    miso_d  = 1'b0;
                    cnt_d   = CW'(ADC_WIDTH - 1);
                    state_d = DATA;
                end
                DATA: if (fall_q) begin
                    miso_d  = shift_q[cnt_q];
                    state_d = (cnt_q == '0) ? TAIL : DATA;
                    cnt_d   = (cnt_q == '0) ? CW'(1) : cnt_q - 1'b1;
                end
                TAIL: begin
                    // cnt_q==1 marks the pending done on the first rise after the LSB
                    if (rise_q && cnt_q == CW'(1)) begin
                        done_d      = 1'b1;
                        done_ch_d   = cmd_q[2:0];
                        done_sgl_d  = cmd_q[3];
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        cnt_d       = '0;
                    end
                    if (fall_q) miso_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
        if (sclr) begin
            sclk_sync_d = '0;
            csn_sync_d  = '1;
            mosi_sync_d = '0;
            rise_d      = 1'b0;
            fall_d      = 1'b0;
            mosi_e_d    = 1'b0;
            state_d     = IDLE;
            cnt_d       = '0;
            cmd_d       = '0;
            shift_d     = '0;
            miso_d      = 1'b0;
            oe_d        = 1'b0;
            done_d      = 1'b0;
            abort_d     = 1'b0;
            done_ch_d   = '0;
            done_sgl_d  = 1'b0;
            frame_cnt_d = '0;
        end
    end

    // csn chain resets high so a csn already low after reset is seen as a frame start
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            mosi_e_q    <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            done_ch_q   <= '0;
            done_sgl_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            mosi_e_q    <= mosi_e_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            done_ch_q   <= done_ch_d;
            done_sgl_q  <= done_sgl_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = oe_q;
    assign done      = done_q;
    assign done_ch   = done_ch_q;
    assign done_sgl  = done_sgl_q;
    assign abort     = abort_q;
    assign frame_cnt = frame_cnt_q;
endmodule
